// File: rtl/alu_share_arbiter_if.sv
// Request/response channels between the issue logic and the shared-ALU arbiter.
// master = issue side (two requesters), slave = arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]        req_op0, req_op1;
  logic [TAG_W-1:0]  req_tag0, req_tag1;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_data0, rsp_data1;
  logic [TAG_W-1:0]  rsp_tag0, rsp_tag1;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
           req_tag0, req_tag1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_tag0, rsp_tag1, rsp_err
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
           req_tag0, req_tag1, rsp_ready,
    output req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_tag0, rsp_tag1, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between the execute path (0)
// and the branch/compare path (1); results land in per-requester response slots.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arbiter_if.slave bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_select,
  input  logic [DATA_W-1:0] alu_out
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b1000, OP_SLL  = 4'b0001, OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011, OP_XOR  = 4'b0100, OP_SRL  = 4'b0101, OP_SRA  = 4'b1101,
    OP_OR   = 4'b0110, OP_AND  = 4'b0111, OP_EQ   = 4'b1010, OP_EQU  = 4'b1011
  } alu_op_e;

  logic              last_grant;
  logic [1:0]        slot_free, cand, grant;
  logic              unsup;
  logic [DATA_W-1:0] cap_data;

  logic [1:0]        rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_data0_q, rsp_data1_q;
  logic [TAG_W-1:0]  rsp_tag0_q, rsp_tag1_q;

  always_comb begin
    slot_free = ~rsp_valid_q | bus.rsp_ready;
    // Held low in reset so nothing is accepted and the ALU sees zeros.
    cand  = rst_n ? (bus.req_valid & slot_free) : '0;
    grant = '0;
    case (cand)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_select = '0;
    if (grant[0]) begin
      alu_a      = bus.req_a0;
      alu_b      = bus.req_b0;
      alu_select = bus.req_op0;
    end else if (grant[1]) begin
      alu_a      = bus.req_a1;
      alu_b      = bus.req_b1;
      alu_select = bus.req_op1;
    end
  end

  always_comb begin
    unsup = 1'b1;
    case (alu_select)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
      OP_SRL, OP_SRA, OP_OR,  OP_AND, OP_EQ,   OP_EQU: unsup = 1'b0;
      default:                                         unsup = 1'b1;
    endcase
    cap_data = unsup ? '0 : alu_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
      rsp_tag0_q  <= '0;
      rsp_tag1_q  <= '0;
      last_grant  <= 1'b1;
    end else begin
      // A grant into an occupied-but-draining slot overwrites and keeps valid set.
      if (grant[0]) begin
        rsp_data0_q    <= cap_data;
        rsp_tag0_q     <= bus.req_tag0;
        rsp_err_q[0]   <= unsup;
        rsp_valid_q[0] <= 1'b1;
      end else if (bus.rsp_ready[0]) begin
        rsp_valid_q[0] <= 1'b0;
      end
      if (grant[1]) begin
        rsp_data1_q    <= cap_data;
        rsp_tag1_q     <= bus.req_tag1;
        rsp_err_q[1]   <= unsup;
        rsp_valid_q[1] <= 1'b1;
      end else if (bus.rsp_ready[1]) begin
        rsp_valid_q[1] <= 1'b0;
      end
      if (|grant) last_grant <= grant[1];
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data0 = rsp_data0_q;
  assign bus.rsp_data1 = rsp_data1_q;
  assign bus.rsp_tag0  = rsp_tag0_q;
  assign bus.rsp_tag1  = rsp_tag1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboarded bench for alu_share_arbiter: directed scenarios then random traffic,
// checked against a transaction-level arbitration/ALU model.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_select;

  int checks   = 0;
  int failures = 0;

  alu_share_arbiter_if #(.DATA_W(32), .TAG_W(4)) bus ();

  alu_share_arbiter #(.DATA_W(32), .TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_out    (alu_out)
  );

  always #5 clk = ~clk;

  // Stand-in for the external ALU; garbage on unsupported codes so it must be masked.
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return {31'd0, $signed(a) < $signed(b)};
      4'b0011: return {31'd0, a < b};
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1010: return {31'd0, a == b};
      4'b1011: return {31'd0, a == b};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_out = alu_model(alu_select, alu_a, alu_b);

  // Expected response packed as {err, tag, data}.
  function automatic logic [36:0] ref_rsp(input logic [3:0] op, input logic [31:0] a, b,
                                          input logic [3:0] tag);
    bit ok;
    ok = op inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                    4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1010, 4'b1011};
    return ok ? {1'b0, tag, alu_model(op, a, b)} : {1'b1, tag, 32'd0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard / monitor
  logic [36:0] q0[$];
  logic [36:0] q1[$];
  logic        lg = 1'b1;
  logic [1:0]  acc = '0;
  logic [1:0]  expv, sf, cand, eg;
  logic [31:0] ea, eb;
  logic [3:0]  es;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
      chk("rst_alu", {alu_a ^ 32'd0, alu_b}, 64'd0);
      chk("rst_alu_sel", {60'd0, alu_select}, 64'd0);
      q0.delete();
      q1.delete();
      lg  = 1'b1;
      acc = '0;
    end else begin
      expv = {q1.size() != 0, q0.size() != 0};
      chk("rsp_valid", {62'd0, bus.rsp_valid}, {62'd0, expv});
      if (expv[0]) chk("rsp0", {27'd0, bus.rsp_err[0], bus.rsp_tag0, bus.rsp_data0}, {27'd0, q0[0]});
      if (expv[1]) chk("rsp1", {27'd0, bus.rsp_err[1], bus.rsp_tag1, bus.rsp_data1}, {27'd0, q1[0]});
      if (expv[0] && bus.rsp_ready[0]) void'(q0.pop_front());
      if (expv[1] && bus.rsp_ready[1]) void'(q1.pop_front());

      sf   = ~expv | bus.rsp_ready;
      cand = bus.req_valid & sf;
      if (cand == 2'b11) eg = (lg == 1'b1) ? 2'b01 : 2'b10;
      else               eg = cand;
      chk("req_ready", {62'd0, bus.req_ready}, {62'd0, eg});

      {ea, eb, es} = '0;
      if (eg[0]) begin
        {ea, eb, es} = {bus.req_a0, bus.req_b0, bus.req_op0};
        q0.push_back(ref_rsp(bus.req_op0, bus.req_a0, bus.req_b0, bus.req_tag0));
        lg = 1'b0;
      end else if (eg[1]) begin
        {ea, eb, es} = {bus.req_a1, bus.req_b1, bus.req_op1};
        q1.push_back(ref_rsp(bus.req_op1, bus.req_a1, bus.req_b1, bus.req_tag1));
        lg = 1'b1;
      end
      chk("alu_ab", {alu_a, alu_b}, {ea, eb});
      chk("alu_sel", {60'd0, alu_select}, {60'd0, es});
      acc = bus.req_ready;
    end
  end

  // Driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic v, input logic [31:0] a, b,
                         input logic [3:0] op, input logic [3:0] tag);
    if (i == 0) begin
      bus.req_valid[0] = v;
      bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op; bus.req_tag0 = tag;
    end else begin
      bus.req_valid[1] = v;
      bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op; bus.req_tag1 = tag;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n         = 1'b0;
    bus.rsp_ready = 2'b11;
    set_req(0, 1'b0, '0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0, '0);
    repeat (3) step();
    rst_n = 1'b1;

    // Single request: 5 - 3 with tag 7
    set_req(0, 1'b1, 32'd5, 32'd3, 4'b1000, 4'd7);
    @(negedge clk);
    chk("t1_ready", {62'd0, bus.req_ready}, 64'd1);
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t1_rsp", {27'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_tag0, bus.rsp_data0},
                  {27'd0, 2'b01, 2'b00, 4'd7, 32'd2});

    // Both requesting every cycle, slots always drained
    step();
    set_req(0, 1'b1, 32'd10, 32'd1, 4'b0000, 4'd1);
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010, 4'd2);
    repeat (8) step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t2_data", {bus.rsp_data0, bus.rsp_data1}, {32'd11, 32'd1});
    repeat (2) step();

    // Requester 0 stalls its response slot
    bus.rsp_ready = 2'b10;
    set_req(0, 1'b1, 32'd100, 32'd1, 4'b0000, 4'd3);
    set_req(1, 1'b1, 32'd7, 32'd7, 4'b1010, 4'd4);
    repeat (5) step();
    @(negedge clk);
    chk("t3_hold_ready", {62'd0, bus.req_ready}, 64'd2);
    chk("t3_hold_data", {31'd0, bus.rsp_valid[0], bus.rsp_data0}, {31'd1, 32'd101});
    step();
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    chk("t3_release", {62'd0, bus.req_ready}, 64'd1);
    step();
    bus.req_valid = 2'b00;
    repeat (2) step();

    // Arithmetic vs logical right shift
    set_req(1, 1'b1, 32'h8000_0000, 32'd4, 4'b1101, 4'd5);
    step();
    set_req(1, 1'b1, 32'h8000_0000, 32'd4, 4'b0101, 4'd6);
    @(negedge clk);
    chk("t4_sra", {32'd0, bus.rsp_data1}, {32'd0, 32'hF800_0000});
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t4_srl", {32'd0, bus.rsp_data1}, {32'd0, 32'h0800_0000});

    // Unsupported op code
    step();
    set_req(0, 1'b1, 32'h1234, 32'h5678, 4'b1111, 4'd9);
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t5_unsup", {30'd0, bus.rsp_err, bus.rsp_data0}, {30'd0, 2'b01, 32'd0});

    // Reset with both slots full, then a tie
    step();
    bus.rsp_ready = 2'b00;
    set_req(0, 1'b1, 32'd1, 32'd2, 4'b0000, 4'd1);
    set_req(1, 1'b1, 32'd3, 32'd4, 4'b0000, 4'd2);
    repeat (4) step();
    @(negedge clk);
    chk("t6_full", {62'd0, bus.rsp_valid}, 64'd3);
    step();
    rst_n = 1'b0;
    step();
    rst_n         = 1'b1;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    chk("t6_cleared", {60'd0, bus.rsp_valid, bus.req_ready}, {60'd0, 2'b00, 2'b01});
    step();
    bus.req_valid = 2'b00;
    repeat (2) step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n = (c % 997 != 500);
      for (int unsigned i = 0; i < 2; i++) begin
        if (acc[i] || !bus.req_valid[i]) begin
          ra = $urandom;
          rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
          set_req(i, $urandom_range(0, 3) != 0, ra, rb, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end
      end
      bus.rsp_ready = 2'($urandom_range(0, 3));
    end

    step();
    rst_n         = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 is the integer execute path, port 1 is the branch/compare path.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin on conflict. The ALU is driven combinationally from the granted request, and its result is registered into a per-requester response slot.
- The block sits between the issue logic and the external ALU instance.

Parameters:
- DATA_W, 32, operand/result width. Must equal the ALU width; only 32 is supported.
- TAG_W, 4, width of the opaque tag echoed from request to response.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester request accepted this cycle.
- req_a0, req_b0  in  DATA_W  requester 0 operands.
- req_a1, req_b1  in  DATA_W  requester 1 operands.
- req_op0, req_op1  in  4  ALU select code per requester.
- req_tag0, req_tag1  in  TAG_W  request tags.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response consumed.
- rsp_data0, rsp_data1  out  DATA_W  registered results.
- rsp_tag0, rsp_tag1  out  TAG_W  echoed tags.
- rsp_err  out  2  per-requester flag: unsupported op code.
- alu_a, alu_b  out  DATA_W  operands to the ALU.
- alu_select  out  4  select to the ALU.
- alu_out  in  DATA_W  combinational ALU result.

Behaviour:
- Supported op codes:
  - add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111, eq 1010, equ 1011.
  - Any other code is unsupported. It is still accepted; the response has rsp_data=0 and rsp_err=1, and the ALU result is ignored.
- Slot free condition: slot_free[i] = !rsp_valid[i] | rsp_ready[i]. A held rsp_ready gives one accept per cycle per requester. req_ready therefore has a combinational path from rsp_ready.
- Candidates: cand = req_valid & slot_free.
- Grant rules:
  - If exactly one candidate exists, it is granted.
  - If both are candidates, the requester not in last_grant is granted.
  - last_grant updates to the granted index on every grant.
  - At most one grant per cycle.
- req_ready[i] = grant[i]. This is a combinational function of req_valid, rsp_valid, rsp_ready and last_grant. There is no dependency on op or data.
- ALU drive:
  - When granted, alu_a/alu_b/alu_select come from the granted requester.
  - When nothing is granted, alu_a=0, alu_b=0, alu_select=0000.
- Capture on the clock edge with grant[i]:
  - rsp_data_i <= alu_out (or 0 if unsupported).
  - rsp_tag_i <= req_tag_i.
  - rsp_err[i] <= unsupported.
  - rsp_valid[i] <= 1.
- Latency: the response is valid on the cycle after accept. Throughput is one op per cycle total.
- Response clear: if rsp_valid[i] & rsp_ready[i] and there is no new grant[i], then rsp_valid[i] <= 0.
- Response hold: while rsp_valid[i] & !rsp_ready[i], rsp_data/tag/err for i are held stable and requester i is not granted. The other requester continues to be served.
- Simultaneous drain and grant on the same port: the new result overwrites; rsp_valid stays 1.
- Requester behaviour assumed: req_valid stays high until accepted, and operands stay stable while valid. The block does not check this.
- Reset (rst_n=0 at a clock edge):
  - rsp_valid=00, rsp_err=00, rsp_data*=0, rsp_tag*=0.
  - last_grant=1, so requester 0 wins the first tie.
- During reset: req_ready=00, and alu outputs are driven 0 / 0000.
- Reset mid-operation discards captured results. A request presented during reset is not accepted.
- Single always-registered state: last_grant, and the rsp_* registers. There are no other counters.

Test Plan:
- Reset, then req_valid=01, req_a0=5, req_b0=3, op0=1000, tag0=7:
  - req_ready=01 that cycle.
  - Next cycle rsp_valid=01, rsp_data0=2, rsp_tag0=7, rsp_err=00.
- Both valid every cycle, rsp_ready=11, op0=0000 (10+1), op1=0010 (a1=FFFFFFFF, b1=1):
  - Grants alternate 0,1,0,1, with requester 0 first after reset.
  - rsp_data0=11; rsp_data1=1 (signed -1<1).
- Requester 0 holds rsp_ready0=0 with rsp_valid0=1, and both request:
  - Requester 1 is granted every cycle; rsp_data0 is unchanged.
  - After rsp_ready0=1, requester 0 is granted that same cycle.
- op1=1101, a1=80000000, b1=4 → rsp_data1=F8000000. op1=0101 with the same operands → 08000000.
- op0=1111 (unsupported) → accepted; next cycle rsp_err=01, rsp_data0=0.
- rst_n=0 for one cycle while rsp_valid=11 → next cycle rsp_valid=00. A following tie grants requester 0.
